// File: rtl/flush_ctrl.sv
// flush_ctrl: exception/eret flush sequencer (IDLE -> REDIRECT -> DRAIN) driving the IF redirect and pipeline flush.
// Define FLUSH_CTRL_PERF_CNT_EN to build the flush-event counter on perf_cnt_o; otherwise it is tied to zero.
module flush_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        except_flush_i,
    input  logic [31:0] except_pc_i,
    input  logic        if_ready_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic [31:0] perf_cnt_o
);
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_e;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            valid_q <= state_d == REDIRECT;
        end
    end

    // A new request always wins, including over a same-cycle acceptance or DRAIN exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        if (except_flush_i) begin
            state_d = REDIRECT;
            pc_d    = except_pc_i;
        end else begin
            case (state_q)
                IDLE:     state_d = IDLE;
                REDIRECT: begin
                    state_d = (valid_q && if_ready_i) ? DRAIN : REDIRECT;
                    cnt_d   = (valid_q && if_ready_i) ? DRAIN_LOAD : cnt_q;
                end
                DRAIN: begin
                    state_d = (cnt_q == 4'd0) ? IDLE : DRAIN;
                    cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o           = state_q != IDLE;
        flush_o          = except_flush_i | busy_o;
        redirect_valid_o = valid_q;
        redirect_pc_o    = pc_q;
    end

`ifdef FLUSH_CTRL_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else if (except_flush_i) perf_q <= perf_q + 32'd1;
    end

    assign perf_cnt_o = perf_q;
`else
    assign perf_cnt_o = 32'b0;
`endif
endmodule
